// File: rtl/counter_arbiter.sv
// Round-robin arbiter/sequencer driving a shared up/down counter for two requesters.
// ack is combinational in IDLE. Counter controls come straight from the state register.
module counter_arbiter #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [3:0]            req_op,
    input  logic [2*WIDTH-1:0]    req_data,
    input  logic [2*STEP_W-1:0]   req_steps,
    output logic [1:0]            ack,
    output logic [1:0]            done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic                  load_n,
    output logic                  ce,
    output logic                  up_down,
    output logic [WIDTH-1:0]      data_load,
    input  logic [WIDTH-1:0]      count_out,
    input  logic                  max_count,
    input  logic                  zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_DOWN  = 2'd2;
    localparam logic [1:0] OP_UPSAT = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              last;
    logic              owner;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  data_q;
    logic [STEP_W-1:0] rem_q;

    logic              gnt;
    logic              grant_en;
    logic              stop;
    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  sel_data;
    logic [STEP_W-1:0] sel_steps;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt       = (req_valid == 2'b11) ? ~last : req_valid[1];
        grant_en  = (state == S_IDLE) && (req_valid != 2'b00) && !rst;
        sel_op    = gnt ? req_op[3:2] : req_op[1:0];
        sel_data  = gnt ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
        sel_steps = gnt ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
    end

    // Flags are checked before ticking so the counter never underflows or wraps on a saturating op.
    always_comb begin
        stop      = ((op_q == OP_DOWN) && zero) || ((op_q == OP_UPSAT) && max_count);
        ack       = grant_en ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        done      = (state == S_DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
        result    = (state == S_DONE) ? count_out : '0;
        busy      = (state != S_IDLE);
        load_n    = (state != S_LOAD);
        data_load = (state == S_LOAD) ? data_q : '0;
        ce        = (state == S_RUN) && !stop;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (grant_en) begin
                    if (sel_op == OP_LOAD)
                        state_nx = S_LOAD;
                    else if (sel_steps == '0)
                        state_nx = S_DONE;
                    else
                        state_nx = S_RUN;
                end
            end
            S_LOAD:  state_nx = S_DONE;
            S_RUN: begin
                if (stop || (rem_q == STEP_W'(1)))
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            owner   <= 1'b0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            rem_q   <= '0;
            up_down <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_en) begin
                last   <= gnt;
                owner  <= gnt;
                op_q   <= sel_op;
                data_q <= sel_data;
                rem_q  <= sel_steps;
                if ((sel_op != OP_LOAD) && (sel_steps != '0))
                    up_down <= (sel_op != OP_DOWN);
            end else if (ce) begin
                rem_q <= rem_q - STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: behavioural counter, directed table, random commands, reset/fairness sequences.
module tb_counter_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [3:0] req_op;
    logic [7:0] req_data;
    logic [15:0] req_steps;
    logic [1:0] ack;
    logic [1:0] done;
    logic [3:0] result;
    logic       busy;
    logic       load_n;
    logic       ce;
    logic       up_down;
    logic [3:0] data_load;
    logic [3:0] count_out;
    logic       max_count;
    logic       zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    counter_arbiter #(.WIDTH(4), .STEP_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_data(req_data), .req_steps(req_steps), .ack(ack), .done(done),
        .result(result), .busy(busy), .load_n(load_n), .ce(ce), .up_down(up_down),
        .data_load(data_load), .count_out(count_out), .max_count(max_count), .zero(zero)
    );

    // The shared counter the arbiter sits in front of.
    logic [3:0] cnt = 4'd0;
    always @(posedge clk) begin
        if (!load_n)
            cnt <= data_load;
        else if (ce)
            cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign count_out = cnt;
    assign max_count = (cnt == 4'hF);
    assign zero      = (cnt == 4'h0);

    typedef struct {
        int         r;
        logic [1:0] op;
        logic [3:0] d;
        logic [7:0] s;
        logic [3:0] res;
        int         lat;
        int         ticks;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Command outcome from the rules: how many ticks fit before a flag stops it, then latency follows.
    function automatic void model(input logic [1:0] op, input logic [3:0] d, input int s,
                                  input logic [3:0] start, output logic [3:0] res,
                                  output int lat, output int ticks);
        int room;
        if (op == 2'd0) begin
            res = d; lat = 2; ticks = 0;
        end else if (s == 0) begin
            res = start; lat = 1; ticks = 0;
        end else begin
            if (op == 2'd1)      room = s;
            else if (op == 2'd2) room = int'(start);
            else                 room = 15 - int'(start);
            if (s <= room) begin
                ticks = s; lat = s + 1;
            end else begin
                ticks = room; lat = room + 2;
            end
            res = (op == 2'd2) ? start - 4'(ticks) : start + 4'(ticks);
        end
    endfunction

    task automatic run_cmd(input int r, input logic [1:0] op, input logic [3:0] d, input logic [7:0] s,
                           output logic [3:0] g_res, output int g_lat, output int g_ticks,
                           output int g_bad);
        int n;
        int lds;
        g_res = 4'd0; g_lat = -1; g_ticks = 0; g_bad = 0; lds = 0;
        @(posedge clk); #1;
        req_op[2*r +: 2]   = op;
        req_data[4*r +: 4] = d;
        req_steps[8*r +: 8] = s;
        req_valid[r] = 1'b1;
        n = 0;
        @(negedge clk);
        while (ack == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ack != (2'b01 << r)) g_bad++;
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        for (int k = 1; k < 400; k++) begin
            @(negedge clk);
            if (ack != 2'b00) g_bad++;
            if (!busy) g_bad++;
            if (ce) begin
                g_ticks++;
                if (up_down != (op != 2'd2)) g_bad++;
                if ((op == 2'd2 && zero) || (op == 2'd3 && max_count)) g_bad++;
            end
            if (!load_n) begin
                lds++;
                if (data_load != d) g_bad++;
            end
            if (done != 2'b00) begin
                if (done != (2'b01 << r)) g_bad++;
                g_res = result;
                g_lat = k;
                break;
            end
        end
        if (lds != ((op == 2'd0) ? 1 : 0)) g_bad++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g_res;
        logic [3:0] e_res;
        logic [3:0] cnt_model;
        int g_lat, g_ticks, g_bad, e_lat, e_ticks, n_done;
        int ack_who[$];
        int ack_cyc[$];

        tbl[0]  = '{0, 2'd0, 4'h9, 8'd0,  4'h9, 2,  0};
        tbl[1]  = '{0, 2'd0, 4'hE, 8'd0,  4'hE, 2,  0};
        tbl[2]  = '{1, 2'd1, 4'h0, 8'd3,  4'h1, 4,  3};
        tbl[3]  = '{0, 2'd0, 4'h3, 8'd0,  4'h3, 2,  0};
        tbl[4]  = '{0, 2'd2, 4'h0, 8'd10, 4'h0, 5,  3};
        tbl[5]  = '{1, 2'd0, 4'hC, 8'd0,  4'hC, 2,  0};
        tbl[6]  = '{1, 2'd3, 4'h0, 8'd10, 4'hF, 5,  3};
        tbl[7]  = '{0, 2'd1, 4'h0, 8'd0,  4'hF, 1,  0};
        tbl[8]  = '{1, 2'd2, 4'h0, 8'd2,  4'hD, 3,  2};
        tbl[9]  = '{0, 2'd3, 4'h0, 8'd1,  4'hE, 2,  1};
        tbl[10] = '{1, 2'd2, 4'h0, 8'd14, 4'h0, 15, 14};
        tbl[11] = '{0, 2'd1, 4'h0, 8'd20, 4'h4, 21, 20};

        rst = 1'b1; req_valid = 2'b00; req_op = 4'd0; req_data = 8'd0; req_steps = 16'd0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_load_n", int'(load_n), 1);
        check("reset_ce", int'(ce), 0);
        check("reset_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].r, tbl[i].op, tbl[i].d, tbl[i].s, g_res, g_lat, g_ticks, g_bad);
            check($sformatf("tbl%0d_result", i), int'(g_res), int'(tbl[i].res));
            check($sformatf("tbl%0d_latency", i), g_lat, tbl[i].lat);
            check($sformatf("tbl%0d_ticks", i), g_ticks, tbl[i].ticks);
            check($sformatf("tbl%0d_protocol", i), g_bad, 0);
        end
        cnt_model = 4'h4;

        for (int i = 0; i < 40; i++) begin
            int r;
            logic [1:0] op;
            logic [3:0] d;
            logic [7:0] s;
            r  = int'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            d  = 4'($urandom_range(0, 15));
            s  = 8'($urandom_range(0, 20));
            model(op, d, int'(s), cnt_model, e_res, e_lat, e_ticks);
            run_cmd(r, op, d, s, g_res, g_lat, g_ticks, g_bad);
            check($sformatf("rnd%0d_result", i), int'(g_res), int'(e_res));
            check($sformatf("rnd%0d_latency", i), g_lat, e_lat);
            check($sformatf("rnd%0d_ticks", i), g_ticks, e_ticks);
            check($sformatf("rnd%0d_protocol", i), g_bad, 0);
            cnt_model = e_res;
        end

        // Abort an UP 50 at its tenth tick.
        @(posedge clk); #1;
        req_op[1:0] = 2'd1; req_steps[7:0] = 8'd50; req_valid = 2'b01;
        n_done = 0;
        for (int k = 0; k < 50 && ack == 2'b00; k++) @(negedge clk);
        check("abort_ack0", int'(ack), 1);
        @(posedge clk); #1 req_valid = 2'b00;
        g_ticks = 0;
        for (int k = 0; k < 40 && g_ticks < 10; k++) begin
            @(negedge clk);
            if (ce) g_ticks++;
        end
        check("abort_ticks_before_rst", g_ticks, 10);
        req_op = 4'b0000; req_data = {4'hA, 4'h5}; req_valid = 2'b11;
        rst = 1'b1;
        #1;
        check("rst_load_n", int'(load_n), 1);
        check("rst_ce", int'(ce), 0);
        check("rst_up_down", int'(up_down), 0);
        check("rst_data_load", int'(data_load), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        req_valid = 2'b00;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done != 2'b00) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Both requesters hold LOAD commands; grants must alternate starting with req0.
        @(posedge clk); #1 req_valid = 2'b11;
        for (int c = 0; c < 60 && ack_who.size() < 4; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                ack_who.push_back(ack == 2'b10 ? 1 : (ack == 2'b01 ? 0 : 9));
                ack_cyc.push_back(c);
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        check("fair_ack_count", ack_who.size(), 4);
        for (int i = 0; i < ack_who.size(); i++)
            check($sformatf("fair_ack%0d_owner", i), ack_who[i], i % 2);
        for (int i = 1; i < ack_cyc.size(); i++)
            check($sformatf("fair_gap%0d_ge3", i), int'(ack_cyc[i] - ack_cyc[i-1] >= 3), 1);
        repeat (4) @(negedge clk);
        check("fair_final_count", int'(count_out), 4'hA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
